// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access legality rule applied when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, RX, WR} lsu_state_t;

  // Stores only exist as SB/SH/SW, so the unsigned load codes are illegal for them
  function automatic logic is_legal(input logic [2:0] funct3, input logic we,
                                    input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    is_legal = 1'b1;
      F3_H:    is_legal = ~addr_lo[0];
      F3_W:    is_legal = (addr_lo == 2'b00);
      F3_BU:   is_legal = ~we;
      F3_HU:   is_legal = ~we & ~addr_lo[0];
      default: is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling shared by loads and read-modify-write stores: extracts and
// extends a byte/halfword from a RAM word, and merges store data into one.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = ram_rdata[7:0];
    sel_half  = byte_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    load_data = ram_rdata;
    merged    = ram_rdata;
    case (byte_off)
      2'd0:    sel_byte = ram_rdata[7:0];
      2'd1:    sel_byte = ram_rdata[15:8];
      2'd2:    sel_byte = ram_rdata[23:16];
      default: sel_byte = ram_rdata[31:24];
    endcase
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = ram_rdata;
    endcase
    // Store data is taken from its low lane and placed at the addressed lane
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// RV32I load/store unit in front of a word-organised RAM without byte
// enables; sub-word stores are performed as read-modify-write.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_rdata
);

  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        off_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [DATA_W-1:0] wbuf_q;
  logic              legal;
  logic [DATA_W-1:0] load_data, merged;
  logic              unused_addr_hi;

  // Address bits above the RAM window simply alias
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign legal = is_legal(req_funct3, req_we, req_addr[1:0]);

  lsu_align u_align (
    .funct3    (funct3_q),
    .byte_off  (off_q),
    .ram_rdata (ram_rdata),
    .wdata     (wbuf_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // RAM strobes come straight from the state so a reset kills them at once
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    ram_rden  = 1'b0;
    ram_wren  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (req_valid && legal)
          state_nxt = (req_we && req_funct3 == F3_W) ? WR : RD;
      end
      RD: begin
        ram_rden  = 1'b1;
        ram_addr  = addr_q;
        state_nxt = RX;
      end
      RX: state_nxt = we_q ? WR : IDLE;
      WR: begin
        ram_wren  = 1'b1;
        ram_addr  = addr_q;
        ram_wdata = wbuf_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wbuf_q holds rs2 until RX, then the merged word for the RMW write
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      addr_q       <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      we_q         <= 1'b0;
      wbuf_q       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr[ADDR_W+1:2];
            off_q    <= req_addr[1:0];
            funct3_q <= req_funct3;
            we_q     <= req_we;
            wbuf_q   <= req_wdata;
            if (!legal) begin
              misalign_err <= 1'b1;
              rsp_valid    <= 1'b1;
            end
          end
        end
        RX: begin
          if (we_q) begin
            wbuf_q <= merged;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
          end
        end
        WR: rsp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
